input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Conditions N_IN raw asynchronous inputs (push-buttons, sensors) for the state-register stage.
//  Per channel: 2-flop synchronizer, counter-based debounce, edge detect.
//  Outputs a clean level, its complement, and 1-cycle rise/fall pulses; level/level_n drive the
//  downstream D flip-flop next-state inputs directly.
//  Complement output resets to 1, matching the downstream flop's NOTQ power-up value.
// PARAMETERS
//  N_IN             4      number of independent input channels
//  DEBOUNCE_CYCLES  50000  consecutive cycles a new value must persist before acceptance (>=1)
//  CNT_W            derived: $clog2(DEBOUNCE_CYCLES+1); localparam, not overridable
// PORTS
//  clock    in   1     single system clock, all logic on posedge
//  reset_n  in   1     synchronous, active-low reset
//  raw_in   in   N_IN  asynchronous raw inputs
//  level    out  N_IN  debounced level per channel
//  level_n  out  N_IN  bitwise complement of level (registered, not a combinational inverter)
//  rise     out  N_IN  1-cycle pulse when level goes 0->1
//  fall     out  N_IN  1-cycle pulse when level goes 1->0
// BEHAVIOUR
//  Interface: one clock, 'clock'; reset 'reset_n' is synchronous and active-low.
//  Reset: sampled on posedge clock while reset_n=0. Effects:
//   - sync flops=0, counter=0, state=STABLE
//   - level=0, level_n=1, rise=0, fall=0
//  Reset mid-debounce discards the pending count; no pulse is emitted.
//  Synchronizer: raw -> s1 -> s2 on every edge. Only s2 feeds the debounce logic.
//  Per-channel FSM:
//   - STABLE: s2==level: hold, cnt=0. s2!=level: cnt<=1, go PENDING.
//   - PENDING: s2==level (glitch ended): cnt<=0, go STABLE, no pulse.
//   - PENDING: s2!=level and cnt==DEBOUNCE_CYCLES-1: level<=s2, level_n<=~s2, cnt<=0, go STABLE;
//     rise or fall asserted for exactly this one cycle.
//   - PENDING: otherwise cnt<=cnt+1.
//   - DEBOUNCE_CYCLES==1: STABLE flips directly; PENDING unused.
//  Latency: raw stable from before edge E0 -> level, level_n and pulse update at edge E0+DEBOUNCE_CYCLES+1.
//  Pulse width: exactly 1 cycle. Pulses cannot repeat within DEBOUNCE_CYCLES cycles on one channel.
//  Glitch rule: any excursion shorter than DEBOUNCE_CYCLES sampled cycles produces no output change.
//  Invariant: level_n == ~level on every cycle. rise & fall never both 1 on one channel.
//  Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//  Channels are fully independent. Simultaneous events on different channels are all honoured
//  in the same cycle.
// STRUCTURE
//  Shared package/header smsl_defs.vh:
//   - state encoding ST_STABLE=1'b0, ST_PENDING=1'b1
//   - default DEBOUNCE_CYCLES constant for the board clock
//  Sub-module debounce_channel: one bit. Contains synchronizer, FSM, counter, pulse regs.
//  Top input_conditioner: generate loop instantiating N_IN debounce_channel.
//  No logic at top level beyond the loop.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, N_IN=4)
//  1. Hold reset_n=0 for 3 edges
//     -> level=4'b0000, level_n=4'b1111, rise=fall=0 after first reset edge.
//  2. raw_in[0] 0->1 before edge 10, held
//     -> level[0]=1, level_n[0]=0, rise[0]=1 after edge 15; rise[0]=0 after edge 16.
//  3. raw_in[1] high for 3 cycles then low
//     -> level[1] stays 0, rise/fall stay 0 throughout.
//  4. raw_in[0] 1->0 after test 2, held
//     -> fall[0] single pulse 5 edges after first sampling edge; level[0]=0, level_n[0]=1.
//  5. raw_in[2] and raw_in[3] rise before the same edge
//     -> rise[3:2]=2'b11 in the same cycle; other channels unaffected.
//  6. raw_in[0] rises, reset_n=0 at edge 13 (mid-count), released at 14, raw held high
//     -> no pulse at 15; level[0]=1 at edge 14+DEBOUNCE_CYCLES+1=19 (edge 14 samples raw into s1).

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce FSM encoding,
// board-clock debounce default and the counter width helper.
package input_conditioner_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input bit: 2-flop synchronizer, counter debounce FSM, registered level/level_n/rise/fall.
// Latency: raw stable before edge E0 appears on outputs after edge E0+DEBOUNCE_CYCLES+1.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic level_n,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_n_q, level_n_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    level_n_d = level_n_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != level_q) begin
          if (DIRECT) begin
            level_d   = sync2_q;
            level_n_d = ~sync2_q;
            rise_d    = sync2_q;
            fall_d    = ~sync2_q;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (sync2_q == level_q) begin
          // excursion ended before acceptance: drop it silently
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          level_d   = sync2_q;
          level_n_d = ~sync2_q;
          rise_d    = sync2_q;
          fall_d    = ~sync2_q;
          cnt_d     = '0;
          state_d   = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_n_q <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      level_n_q <= level_n_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign level   = level_q;
  assign level_n = level_n_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// N_IN independent debounced input channels; no shared logic between channels.
// Each channel updates DEBOUNCE_CYCLES+1 edges after its raw input settles.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] level_n,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall
);

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .raw_in (raw_in[g]),
      .level  (level[g]),
      .level_n(level_n[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, N_IN=4; expected pulses are queued
// at stimulus time and checked each cycle against the DUT outputs.
module tb_input_conditioner;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct {
    int       edge_no;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] level, level_n, rise, fall;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   rst_s = 0;
  bit   mon_en = 0;
  logic [N-1:0] lvl_m = '0;
  exp_t sb_q[$];

  input_conditioner #(.N_IN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (raw_in),
    .level  (level),
    .level_n(level_n),
    .rise   (rise),
    .fall   (fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    edge_cnt = edge_cnt + 1;
    rst_s    = !reset_n;
  end

  // Scoreboard monitor: pops pulses due at this edge and tracks the expected level.
  always @(negedge clock) begin
    logic [N-1:0] er, ef;
    er = '0;
    ef = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].edge_no == edge_cnt) begin
        er |= sb_q[i].rise;
        ef |= sb_q[i].fall;
        sb_q.delete(i);
      end
    end
    if (rst_s) lvl_m = '0;
    else       lvl_m = (lvl_m | er) & ~ef;
    if (mon_en) begin
      checks++;
      if (rise !== er) begin
        errors++;
        $display("FAIL mon_rise edge %0d: got %b expected %b", edge_cnt, rise, er);
      end
      checks++;
      if (fall !== ef) begin
        errors++;
        $display("FAIL mon_fall edge %0d: got %b expected %b", edge_cnt, fall, ef);
      end
      checks++;
      if (level !== lvl_m) begin
        errors++;
        $display("FAIL mon_level edge %0d: got %b expected %b", edge_cnt, level, lvl_m);
      end
      checks++;
      if (level_n !== ~lvl_m) begin
        errors++;
        $display("FAIL mon_level_n edge %0d: got %b expected %b", edge_cnt, level_n, ~lvl_m);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic goto_after(input int k);
    while (edge_cnt < k) @(negedge clock);
  endtask

  task automatic test_reset();
    goto_after(1);
    checks++;
    if (level !== 4'b0000 || level_n !== 4'b1111) begin
      errors++;
      $display("FAIL reset_level: got level=%b level_n=%b expected 0000/1111", level, level_n);
    end
    checks++;
    if (rise !== 4'b0000 || fall !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulse: got rise=%b fall=%b expected 0000/0000", rise, fall);
    end
    mon_en = 1;
    goto_after(3);
    reset_n = 1'b1;
  endtask

  task automatic test_rise();
    goto_after(9);
    raw_in[0] = 1'b1;
    sb_q.push_back('{edge_no: 15, rise: 4'b0001, fall: 4'b0000});
    goto_after(14);
    checks++;
    if (level[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_early: level[0] got %b expected 0 at edge 14", level[0]);
    end
    goto_after(15);
    checks++;
    if (level[0] !== 1'b1 || level_n[0] !== 1'b0 || rise[0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_edge15: got level=%b level_n=%b rise=%b expected 1/0/1",
               level[0], level_n[0], rise[0]);
    end
    goto_after(16);
    checks++;
    if (rise[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_width: rise[0] got %b expected 0 at edge 16", rise[0]);
    end
  endtask

  task automatic test_glitch();
    goto_after(17);
    raw_in[1] = 1'b1;
    goto_after(20);
    raw_in[1] = 1'b0;
    goto_after(30);
    checks++;
    if (level[1] !== 1'b0 || level_n[1] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_level: got level=%b level_n=%b expected 0/1", level[1], level_n[1]);
    end
  endtask

  task automatic test_fall();
    raw_in[0] = 1'b0;
    sb_q.push_back('{edge_no: 36, rise: 4'b0000, fall: 4'b0001});
    goto_after(36);
    checks++;
    if (fall[0] !== 1'b1 || level[0] !== 1'b0 || level_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL fall_edge36: got fall=%b level=%b level_n=%b expected 1/0/1",
               fall[0], level[0], level_n[0]);
    end
    goto_after(37);
    checks++;
    if (fall[0] !== 1'b0) begin
      errors++;
      $display("FAIL fall_width: fall[0] got %b expected 0 at edge 37", fall[0]);
    end
  endtask

  task automatic test_simultaneous();
    goto_after(40);
    raw_in[3:2] = 2'b11;
    sb_q.push_back('{edge_no: 46, rise: 4'b1100, fall: 4'b0000});
    goto_after(46);
    checks++;
    if (rise !== 4'b1100 || level !== 4'b1100) begin
      errors++;
      $display("FAIL simul_rise: got rise=%b level=%b expected 1100/1100", rise, level);
    end
  endtask

  task automatic test_reset_mid();
    goto_after(50);
    raw_in[0] = 1'b1;
    goto_after(53);
    reset_n = 1'b0;
    goto_after(54);
    reset_n = 1'b1;
    // channels 2/3 were cleared by reset but their raw inputs are still high
    sb_q.push_back('{edge_no: 60, rise: 4'b1101, fall: 4'b0000});
    checks++;
    if (level !== 4'b0000 || level_n !== 4'b1111) begin
      errors++;
      $display("FAIL midrst_clear: got level=%b level_n=%b expected 0000/1111", level, level_n);
    end
    goto_after(56);
    checks++;
    if (rise !== 4'b0000 || level[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nopulse: got rise=%b level[0]=%b expected 0000/0", rise, level[0]);
    end
    goto_after(60);
    checks++;
    if (level !== 4'b1101 || rise !== 4'b1101) begin
      errors++;
      $display("FAIL midrst_level: got level=%b rise=%b expected 1101/1101", level, rise);
    end
  endtask

  task automatic test_back_to_back();
    goto_after(62);
    raw_in = 4'b0000;
    sb_q.push_back('{edge_no: 68, rise: 4'b0000, fall: 4'b1101});
    goto_after(68);
    checks++;
    if (fall !== 4'b1101 || level_n !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_fall: got fall=%b level_n=%b expected 1101/1111", fall, level_n);
    end
    goto_after(72);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
